cache_line_mover: RTL and testbench
===================================

# cache_line_mover

Beat sequencer for the 1024×64 synchronous cache data array (one-cycle registered read, separate read/write ports). It sits directly in front of the array and owns both of its ports. A refill streams eight 64-bit beats from the memory side into one line. An evict reads one line out of the array and streams it to the memory side under valid/ready backpressure.

## Interface
- `LINE_LOG2`, default 3: log2 of beats per line; a line is 8 × 64 bit = 64 B.
- `ADDR_W`, default 10: array address width; the line index is `ADDR_W-LINE_LOG2` = 7 bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted; high only in IDLE.
- `req_op`  in  1  0 = refill, 1 = evict.
- `req_line`  in  7  line index.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `in_valid`  in  1  refill beat valid.
- `in_ready`  out  1  high only in FILL.
- `in_data`  in  64  refill beat.
- `out_valid`  out  1  evict FIFO non-empty.
- `out_ready`  in  1  evict beat consumed.
- `out_data`  out  64  evict FIFO head.
- `out_last`  out  1  head is beat 7.
- `ram_raddr`  out  10  array read address.
- `ram_rd`  in  64  array read data; valid the cycle after `ram_raddr`.
- `ram_waddr`  out  10  array write address.
- `ram_wr`  out  64  array write data.
- `ram_we`  out  1  array write enable.

## Operation
- States:
  - IDLE: `req_valid` → FILL if `req_op`=0, EVICT if `req_op`=1. Latch `req_line`; clear beat counters.
  - FILL: last beat written → IDLE.
  - EVICT: last beat popped → IDLE.
- FILL:
  - `ram_we = in_valid`, `ram_waddr = {line, wbeat}`, `ram_wr = in_data`; all combinational.
  - `wbeat` increments on each `in_valid & in_ready`.
  - A stall (`in_valid`=0) writes nothing and holds `wbeat`.
  - On the beat-7 handshake: go to IDLE and set `done` for the next cycle.
- EVICT:
  - FIFO is 3 deep. `inflight` is a 1-bit flag meaning "read issued last cycle".
  - Issue rule: issue a read when `rbeat` ≤ 7 and `count + inflight` < 3, regardless of pop. On issue, `ram_raddr = {line, rbeat}` and `rbeat` increments.
  - When not issuing, `ram_raddr` holds its last value; the data returned for it is ignored.
  - Capture: if `inflight`, push `ram_rd` at the clock edge.
  - Pop: on `out_valid & out_ready`.
  - `out_last` is tracked per entry: set on the entry captured for beat 7.
  - Pushing and popping in the same cycle is legal, including at count 3 with pop (occupancy unchanged).
  - On popping the `out_last` entry: go to IDLE and pulse `done` the next cycle. FIFO is empty at that point.
- `ram_we` is 0 outside FILL. Read and write addresses never collide, because only one command is active at a time.
- Reset (`rst`=0 at an edge), including mid-command:
  - State → IDLE; counters, FIFO and `inflight` cleared.
  - Outputs: `ram_we`=0, `done`=0, `out_valid`=0, `busy`=0, `req_ready`=1 after the edge.
  - The partial line is abandoned; no further writes occur.

## Timing
- A request accepted at edge E makes `busy`=1 from E.
- Refill:
  - First write possible in the cycle after E.
  - 8 back-to-back beats take 8 cycles.
  - `done` pulses in the cycle after the last write. `req_ready` is high in that same cycle, so a new request can be accepted there.
- Evict:
  - Read of beat 0 is issued in cycle E+1; the data is captured at E+3.
  - `out_valid` is first high in cycle E+3, i.e. the third cycle after acceptance.
  - With `out_ready` held at 1, beats appear on consecutive cycles E+3..E+10.
  - `done` pulses at E+11.
- Backpressure never drops or duplicates a beat.
- `out_data` and `out_last` are stable while `out_valid` && !`out_ready`.

## Test plan
- Refill line 5, beats `0x1000+i` with no stalls → `ram_we` high 8 cycles at addresses 40..47 in order; `done` pulses once, one cycle after the address-47 write; `busy` falls with it.
- Refill line 127 with `in_valid` deasserted on beats 2 and 6 for 3 cycles each → exactly 8 writes to addresses 1016..1023; stalled cycles have `ram_we`=0.
- Evict line 5 (preloaded `0xA0+i`) with `out_ready`=1 → `out_valid` at E+3..E+10, data `0xA0..0xA7`, `out_last` only on `0xA7`, `done` at E+11.
- Evict with `out_ready` random at 30% → output order `0xA0..0xA7` with no loss; FIFO count never exceeds 3.
- `rst`=0 asserted after the 4th beat of a refill → no writes after reset; `req_ready`=1, `done`=0 next cycle. A following evict of the same line returns beats 0–3 new and beats 4–7 old.
- `req_valid` held high through a refill → the second request is accepted in the `done` cycle, not earlier; back-to-back refill then evict both complete with correct data.

Source files
------------

// File: rtl/cache_line_mover.sv
// cache_line_mover
// Beat sequencer in front of a 2^ADDR_W x 64 synchronous data array (one-cycle
// registered read, separate read and write ports). A refill streams
// 2^LINE_LOG2 beats from in_* into one line. An evict reads one line and
// streams it out on out_* through a 3-entry FIFO under valid/ready.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   req_valid/ready/op/line   command: op 0 = refill, 1 = evict; line index
//   busy, done                command in progress / one-cycle completion pulse
//   in_valid/ready/data       refill beat stream
//   out_valid/ready/data/last evict beat stream, out_last marks the final beat
//   ram_raddr, ram_rd         array read port (data valid the cycle after addr)
//   ram_waddr, ram_wr, ram_we array write port
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a command; req_ready high
// ST_FILL  | writing refill beats straight through to the array
// ST_EVICT | issuing array reads, buffering returns, draining to out_*
module cache_line_mover #(
    parameter int LINE_LOG2 = 3,
    parameter int ADDR_W    = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_op,
    input  logic [ADDR_W-LINE_LOG2-1:0] req_line,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [63:0]                 in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [63:0]                 out_data,
    output logic                        out_last,
    output logic [ADDR_W-1:0]           ram_raddr,
    input  logic [63:0]                 ram_rd,
    output logic [ADDR_W-1:0]           ram_waddr,
    output logic [63:0]                 ram_wr,
    output logic                        ram_we
);

    localparam int LINE_W = ADDR_W - LINE_LOG2;
    localparam logic [LINE_LOG2:0]   RB_END    = (LINE_LOG2 + 1)'(1 << LINE_LOG2);
    localparam logic [LINE_LOG2:0]   RB_ONE    = (LINE_LOG2 + 1)'(1);
    localparam logic [LINE_LOG2-1:0] WB_ONE    = LINE_LOG2'(1);
    localparam logic [LINE_LOG2-1:0] BEAT_LAST = LINE_LOG2'((1 << LINE_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_EVICT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [LINE_LOG2-1:0]   wbeat_q, wbeat_d;
    logic [LINE_LOG2:0]     rbeat_q, rbeat_d;
    logic                   start_q, start_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic [ADDR_W-1:0]      raddr_q, raddr_d;
    logic [1:0]             wptr_q, wptr_d;
    logic [1:0]             rptr_q, rptr_d;
    logic [1:0]             count_q, count_d;
    logic                   done_q, done_d;
    logic [63:0]            fifo_data_q [3];
    logic [63:0]            fifo_data_d [3];
    logic                   fifo_last_q [3];
    logic                   fifo_last_d [3];

    logic issue;
    logic push;
    logic pop;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign in_ready  = (state_q == ST_FILL);
    assign ram_we    = in_ready & in_valid;
    assign ram_waddr = {line_q, wbeat_q};
    assign ram_wr    = in_data;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_data_q[rptr_q];
    assign out_last  = out_valid & fifo_last_q[rptr_q];

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        wbeat_d     = wbeat_q;
        rbeat_d     = rbeat_q;
        start_d     = start_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        ram_raddr   = raddr_q;
        push        = inflight_q;
        pop         = out_valid & out_ready;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    line_d  = req_line;
                    wbeat_d = '0;
                    rbeat_d = '0;
                    start_d = 1'b1;
                    state_d = req_op ? ST_EVICT : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    wbeat_d = wbeat_q + WB_ONE;
                    if (wbeat_q == BEAT_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_EVICT: begin
                // First EVICT cycle only settles the latched line; reads start
                // the cycle after so beat 0 lands in the FIFO three cycles
                // after acceptance. Reads in flight count against FIFO space
                // so a returning beat always has a slot, even with no pop.
                start_d = 1'b0;
                issue   = !start_q && (rbeat_q < RB_END) &&
                          (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
                if (issue) begin
                    ram_raddr = {line_q, rbeat_q[LINE_LOG2-1:0]};
                    rbeat_d   = rbeat_q + RB_ONE;
                end
                if (pop && fifo_last_q[rptr_q]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        raddr_d         = ram_raddr;
        inflight_d      = issue;
        inflight_last_d = issue && (rbeat_q[LINE_LOG2-1:0] == BEAT_LAST);

        if (push) begin
            fifo_data_d[wptr_q] = ram_rd;
            fifo_last_d[wptr_q] = inflight_last_q;
            wptr_d = (wptr_q == 2'd2) ? 2'd0 : wptr_q + 2'd1;
        end
        if (pop) begin
            rptr_d = (rptr_q == 2'd2) ? 2'd0 : rptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            line_q          <= '0;
            wbeat_q         <= '0;
            rbeat_q         <= '0;
            start_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            raddr_q         <= '0;
            wptr_q          <= 2'd0;
            rptr_q          <= 2'd0;
            count_q         <= 2'd0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            line_q          <= line_d;
            wbeat_q         <= wbeat_d;
            rbeat_q         <= rbeat_d;
            start_q         <= start_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            raddr_q         <= raddr_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            done_q          <= done_d;
        end
    end

    // FIFO storage needs no reset: occupancy is cleared, so stale entries are
    // never presented.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_last_q <= fifo_last_d;
    end

endmodule

// File: tb/tb_cache_line_mover.sv
module tb_cache_line_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [6:0]  req_line;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic [9:0]  ram_raddr;
    logic [63:0] ram_rd;
    logic [9:0]  ram_waddr;
    logic [63:0] ram_wr;
    logic        ram_we;

    always #5 clk = ~clk;

    cache_line_mover dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_line(req_line),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ram_raddr(ram_raddr), .ram_rd(ram_rd),
        .ram_waddr(ram_waddr), .ram_wr(ram_wr), .ram_we(ram_we)
    );

    // Synchronous data array the DUT drives.
    logic [63:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_waddr] <= ram_wr;
        ram_rd <= mem[ram_raddr];
    end

    typedef struct {
        logic [9:0]  addr;
        logic [63:0] data;
        bit          last;
    } exp_t;

    exp_t        wq[$];
    exp_t        oq[$];
    logic [63:0] shadow [0:1023];
    logic [63:0] got_out [0:7];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int done_cyc = -1;
    int first_valid_cyc = -1;
    int first_waddr = -1;
    int last_waddr = -1;
    int n_we = 0;
    int n_pop = 0;
    int rmode = 2;
    bit mon_en = 0;
    bit busy_m = 0;
    bit fill_m = 0;
    bit done_exp = 0;
    bit prev_hold = 0;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [63:0] last_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got missing/unexpected event want expected event (cycle %0d)", name, cyc);
    endtask

    function automatic exp_t mk(input int addr, input logic [63:0] data, input bit last);
        exp_t e;
        e.addr = 10'(addr);
        e.data = data;
        e.last = last;
        return e;
    endfunction

    // Spec-level model: busy from acceptance to the final write/pop, done the
    // cycle after that, writes and beats in line order from the queues.
    always @(negedge clk) begin
        exp_t e;
        bit   fin;
        if (mon_en) begin
            check("done", 64'(done), 64'(done_exp));
            check("busy", 64'(busy), 64'(busy_m));
            check("req_ready", 64'(req_ready), 64'(!busy_m));
            check("in_ready", 64'(in_ready), 64'(fill_m));
            check("ram_we", 64'(ram_we), 64'(fill_m && in_valid));
            if (ram_we === 1'b1) n_we++;
            fin = 0;
            if (fill_m && in_valid) begin
                if (wq.size() == 0) fail_now("write_unexpected");
                else begin
                    e = wq.pop_front();
                    check("ram_waddr", 64'(ram_waddr), 64'(e.addr));
                    check("ram_wr", ram_wr, e.data);
                    shadow[e.addr] = e.data;
                    if (first_waddr < 0) first_waddr = int'(ram_waddr);
                    last_waddr = int'(ram_waddr);
                    fin = e.last;
                end
            end
            if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (oq.size() == 0) fail_now("beat_unexpected");
                else begin
                    e = oq.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", 64'(out_last), 64'(e.last));
                    if (n_pop < 8) got_out[n_pop] = out_data;
                    n_pop++;
                    last_out = out_data;
                    fin = fin | e.last;
                end
            end
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", out_data, prev_data);
                check("hold_last", 64'(out_last), 64'(prev_last));
            end
            prev_hold = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data = out_data;
            prev_last = out_last;
            if (done === 1'b1) done_cyc = cyc;
            if (!rst) begin
                busy_m = 0; fill_m = 0; done_exp = 0; prev_hold = 0;
            end else begin
                done_exp = fin;
                if (!busy_m && req_valid) begin
                    busy_m = 1; fill_m = !req_op; acc_cnt++; acc_cyc = cyc + 1;
                end else if (fin) begin
                    busy_m = 0; fill_m = 0;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 9) < 3);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int n0, input string name);
        int k = 0;
        while (acc_cnt == n0 && k < 50) begin tick(); k++; end
        if (acc_cnt == n0) fail_now(name);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((busy_m || wq.size() != 0 || oq.size() != 0) && k < 300) begin tick(); k++; end
        if (busy_m || wq.size() != 0 || oq.size() != 0) fail_now(name);
        tick();
        tick();
    endtask

    task automatic refill(input logic [6:0] line, input logic [63:0] base,
                          input int stall_a, input int stall_b, input int beats, input bit hold);
        int n0 = acc_cnt;
        for (int i = 0; i < 8; i++) wq.push_back(mk(int'(line) * 8 + i, base + 64'(i), i == 7));
        req_line = line; req_op = 1'b0; req_valid = 1'b1;
        wait_accept(n0, "refill_accept");
        if (hold) req_op = 1'b1;
        else      req_valid = 1'b0;
        for (int i = 0; i < beats; i++) begin
            if (i == stall_a || i == stall_b) begin
                in_valid = 1'b0;
                repeat (3) tick();
            end
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic evict(input logic [6:0] line);
        int n0 = acc_cnt;
        for (int i = 0; i < 8; i++) oq.push_back(mk(0, shadow[int'(line) * 8 + i], i == 7));
        n_pop = 0; first_valid_cyc = -1;
        req_line = line; req_op = 1'b1; req_valid = 1'b1;
        wait_accept(n0, "evict_accept");
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_line = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) tick();
        rst = 1'b1;
        mon_en = 1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_ram_we", 64'(ram_we), 64'(0));
        tick();

        // Refill line 5, no stalls: addresses 40..47, done one cycle after the last write.
        n_we = 0; first_waddr = -1;
        refill(7'd5, 64'h1000, -1, -1, 8, 0);
        wait_done("t1_done");
        check("t1_writes", 64'(n_we), 64'(8));
        check("t1_first_addr", 64'(first_waddr), 64'(40));
        check("t1_last_addr", 64'(last_waddr), 64'(47));
        check("t1_done_lat", 64'(done_cyc - acc_cyc), 64'(8));

        // Refill line 127, 3-cycle stalls before beats 2 and 6.
        n_we = 0; first_waddr = -1;
        refill(7'd127, 64'h3000, 2, 6, 8, 0);
        wait_done("t2_done");
        check("t2_writes", 64'(n_we), 64'(8));
        check("t2_first_addr", 64'(first_waddr), 64'(1016));
        check("t2_last_addr", 64'(last_waddr), 64'(1023));
        check("t2_done_lat", 64'(done_cyc - acc_cyc), 64'(14));

        // Preload line 5 with 0xA0+i.
        refill(7'd5, 64'hA0, -1, -1, 8, 0);
        wait_done("preload_done");

        // Evict line 5, out_ready held high.
        rmode = 0;
        tick();
        evict(7'd5);
        wait_done("t3_done");
        check("t3_first_valid", 64'(first_valid_cyc - acc_cyc), 64'(3));
        check("t3_done_lat", 64'(done_cyc - acc_cyc), 64'(11));
        check("t3_beats", 64'(n_pop), 64'(8));
        check("t3_last_data", last_out, 64'hA7);

        // Evict with out_ready random at 30%.
        rmode = 1;
        evict(7'd5);
        wait_done("t4_done");
        check("t4_beats", 64'(n_pop), 64'(8));
        check("t4_beat0", got_out[0], 64'hA0);

        // Evict with the sink stalled long enough to fill the FIFO.
        rmode = 2;
        tick();
        evict(7'd5);
        repeat (14) tick();
        check("t4b_stalled_valid", 64'(out_valid), 64'(1));
        rmode = 0;
        wait_done("t4b_done");
        check("t4b_beats", 64'(n_pop), 64'(8));
        check("t4b_beat7", got_out[7], 64'hA7);

        // Reset after the 4th beat of a refill.
        refill(7'd5, 64'h2000, -1, -1, 4, 0);
        rst = 1'b0;
        tick();
        check("t5_unwritten", 64'(wq.size()), 64'(4));
        wq.delete();
        rst = 1'b1;
        n_we = 0;
        in_valid = 1'b1; in_data = 64'hDEAD;
        repeat (3) tick();
        in_valid = 1'b0;
        check("t5_no_writes", 64'(n_we), 64'(0));
        evict(7'd5);
        wait_done("t5_evict_done");
        check("t5_beat3_new", got_out[3], 64'h2003);
        check("t5_beat4_old", got_out[4], 64'hA4);

        // req_valid held through a refill; the evict behind it is taken in the done cycle.
        n0 = acc_cnt;
        for (int i = 0; i < 8; i++) oq.push_back(mk(0, 64'h4000 + 64'(i), i == 7));
        n_pop = 0;
        refill(7'd9, 64'h4000, -1, -1, 8, 1);
        begin
            int k = 0;
            while (acc_cnt < n0 + 2 && k < 50) begin tick(); k++; end
        end
        req_valid = 1'b0;
        check("t6_accepts", 64'(acc_cnt - n0), 64'(2));
        check("t6_accept_in_done", 64'(acc_cyc), 64'(done_cyc + 1));
        wait_done("t6_done");
        check("t6_beats", 64'(n_pop), 64'(8));
        check("t6_beat7", got_out[7], 64'h4007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
